divs_n6d3: RTL and testbench

//   Sequential signed divider, the inverse of the team's signed small-operand

---
 rtl/divs_n6d3.sv | 149 ++++++++++++++
 tb/tb_divs_n6d3.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/divs_n6d3.sv
// divs_n6d3: sequential signed divider.
// Restoring division on operand magnitudes, one quotient bit per clock, with
// a sign fix-up on the final iteration. Results are sign-magnitude {s, q} and
// {rs, r}. Truncating division; the remainder takes the dividend's sign.
module divs_n6d3 #(
  parameter int WIDTH_N = 6,
  parameter int WIDTH_D = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH_N-1:0] n,
  input  logic [WIDTH_D-1:0] d,
  output logic [WIDTH_N-1:0] q,
  output logic               s,
  output logic [WIDTH_D-1:0] r,
  output logic               rs,
  output logic               div0,
  output logic               busy,
  output logic               rdy
);

  localparam int CW = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH_N-1:0] nq;      // dividend bits shift out MSB-first, quotient bits shift in
  logic [WIDTH_D-1:0] ad;      // divisor magnitude
  logic [WIDTH_D:0]   pr;      // partial remainder
  logic [CW-1:0]      cnt;
  logic               sn;
  logic               sd;
  logic               zero;    // divide-by-zero operation in flight

  logic [WIDTH_N-1:0] n_abs;
  logic [WIDTH_D-1:0] d_abs;
  logic [WIDTH_D:0]   pr_shift;
  logic [WIDTH_D:0]   pr_next;
  logic               qbit;
  logic [WIDTH_N-1:0] q_final;
  logic [WIDTH_D-1:0] r_final;
  logic               accept;

  // Operand magnitudes and one restoring-division step on the current state.
  // Because pr stays below |d| <= 2^WIDTH_D, dropping pr's MSB on the shift
  // loses nothing.
  always_comb begin
    n_abs    = n[WIDTH_N-1] ? -n : n;
    d_abs    = d[WIDTH_D-1] ? -d : d;
    pr_shift = {pr[WIDTH_D-1:0], nq[WIDTH_N-1]};
    if (pr_shift >= {1'b0, ad}) begin
      pr_next = pr_shift - {1'b0, ad};
      qbit    = 1'b1;
    end else begin
      pr_next = pr_shift;
      qbit    = 1'b0;
    end
    q_final = {nq[WIDTH_N-2:0], qbit};
    r_final = pr_next[WIDTH_D-1:0];
    accept  = start && ((state == IDLE) || (state == DONE));
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      nq    <= {WIDTH_N{1'b0}};
      ad    <= {WIDTH_D{1'b0}};
      pr    <= {(WIDTH_D+1){1'b0}};
      cnt   <= {CW{1'b0}};
      sn    <= 1'b0;
      sd    <= 1'b0;
      zero  <= 1'b0;
      q     <= {WIDTH_N{1'b0}};
      s     <= 1'b0;
      r     <= {WIDTH_D{1'b0}};
      rs    <= 1'b0;
      div0  <= 1'b0;
      busy  <= 1'b0;
      rdy   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            // A zero divisor takes a single pass through CALC so its result
            // appears one clock after start and rdy visibly re-rises.
            state <= CALC;
            nq    <= n_abs;
            ad    <= d_abs;
            pr    <= {(WIDTH_D+1){1'b0}};
            cnt   <= (d == {WIDTH_D{1'b0}}) ? {CW{1'b0}} : CW'(WIDTH_N - 1);
            sn    <= n[WIDTH_N-1];
            sd    <= d[WIDTH_D-1];
            zero  <= (d == {WIDTH_D{1'b0}});
            q     <= {WIDTH_N{1'b0}};
            s     <= 1'b0;
            r     <= {WIDTH_D{1'b0}};
            rs    <= 1'b0;
            div0  <= 1'b0;
            busy  <= 1'b1;
            rdy   <= 1'b0;
          end else begin
            state <= state;
          end
        end
        CALC: begin
          if (zero) begin
            state <= DONE;
            zero  <= 1'b0;
            q     <= {WIDTH_N{1'b1}};
            s     <= 1'b0;
            r     <= {WIDTH_D{1'b0}};
            rs    <= 1'b0;
            div0  <= 1'b1;
            busy  <= 1'b0;
            rdy   <= 1'b1;
          end else begin
            pr  <= pr_next;
            nq  <= q_final;
            cnt <= cnt - CW'(1);
            if (cnt == {CW{1'b0}}) begin
              state <= DONE;
              q     <= q_final;
              r     <= r_final;
              s     <= (sn ^ sd) & (q_final != {WIDTH_N{1'b0}});
              rs    <= sn & (r_final != {WIDTH_D{1'b0}});
              busy  <= 1'b0;
              rdy   <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          rdy   <= 1'b0;
          div0  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divs_n6d3.sv
// Testbench for divs_n6d3: directed cases, an exhaustive operand sweep and a
// randomized run. Stimulus pushes expected results into a scoreboard; a
// monitor pops and compares on every rising edge of rdy.
module tb_divs_n6d3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] n;
  logic [2:0] d;
  logic [5:0] q;
  logic       s;
  logic [2:0] r;
  logic       rs;
  logic       div0;
  logic       busy;
  logic       rdy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int q; int s; int r; int rs; int z; int nv; int dv; int c;
  } exp_t;
  exp_t sb[$];

  divs_n6d3 dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .d(d),
    .q(q), .s(s), .r(r), .rs(rs), .div0(div0), .busy(busy), .rdy(rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division (truncates toward zero, remainder
  // follows the dividend) split into sign-magnitude fields.
  function automatic exp_t model(input int nv, input int dv, input int c);
    exp_t e;
    int   qv;
    int   rv;
    e.nv = nv; e.dv = dv; e.c = c;
    if (dv == 0) begin
      e.q = 63; e.s = 0; e.r = 0; e.rs = 0; e.z = 1;
    end else begin
      qv   = nv / dv;
      rv   = nv % dv;
      e.q  = (qv < 0) ? -qv : qv;
      e.s  = (qv < 0) ? 1 : 0;
      e.r  = (rv < 0) ? -rv : rv;
      e.rs = (rv < 0) ? 1 : 0;
      e.z  = 0;
    end
    return e;
  endfunction

  // Drive a one-cycle start; returns just after the sampling edge.
  task automatic issue(input int nv, input int dv, input bit push);
    n     = nv[5:0];
    d     = dv[2:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) sb.push_back(model(nv, dv, cyc + ((dv == 0) ? 1 : 6)));
  endtask

  task automatic wait_rdy(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = rdy;
    end
    chk(name, int'(got), 1);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_rdy"},  int'(rdy), 0);
    chk({name, "_outs"}, int'({q, s, r, rs, div0}), 0);
  endtask

  // Monitor: compare against the scoreboard whenever rdy rises.
  logic rdy_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int   qs;
    int   rsv;
    if (rdy && !rdy_q) begin
      if (sb.size() == 0) begin
        chk("sb_has_entry", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("q",       int'(q),    e.q);
        chk("s",       int'(s),    e.s);
        chk("r",       int'(r),    e.r);
        chk("rs",      int'(rs),   e.rs);
        chk("div0",    int'(div0), e.z);
        chk("latency", cyc,        e.c);
        chk("busy_in_done", int'(busy), 0);
        if (e.dv != 0) begin
          qs  = s  ? -int'(q) : int'(q);
          rsv = rs ? -int'(r) : int'(r);
          chk("identity", qs * e.dv + rsv, e.nv);
        end
      end
    end
    rdy_q <= rdy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; n = 6'd0; d = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    issue(23, 3, 1);    wait_rdy("rdy_23_3");
    issue(-32, -1, 1);  wait_rdy("rdy_m32_m1");
    issue(-29, 3, 1);   wait_rdy("rdy_m29_3");
    issue(5, -4, 1);    wait_rdy("rdy_5_m4");
    issue(-2, 3, 1);    wait_rdy("rdy_m2_3");
    issue(10, 0, 1);    wait_rdy("rdy_10_0");

    // start during CALC is ignored.
    issue(23, 3, 1);
    @(posedge clk); @(posedge clk); #1;
    n = 6'd1; d = 3'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("calc_busy", int'(busy), 1);
    chk("calc_rdy",  int'(rdy), 0);
    wait_rdy("rdy_ignored_start");

    // start while DONE drops rdy on the next cycle.
    @(posedge clk); #1;
    issue(1, 1, 1);
    @(negedge clk);
    chk("done_restart_rdy", int'(rdy), 0);
    wait_rdy("rdy_1_1");

    // Reset mid-CALC aborts.
    @(posedge clk); #1;
    issue(23, 3, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("idle_after_reset_rdy", int'(rdy), 0);
    @(posedge clk); #1;

    // Exhaustive sweep of all operand pairs.
    for (int a = -32; a < 32; a++) begin
      for (int b = -4; b < 4; b++) begin
        issue(a, b, 1);
        wait_rdy("rdy_sweep");
        @(posedge clk); #1;
      end
    end

    // Randomized operations with random gaps and don't-care operand churn.
    for (int i = 0; i < 300; i++) begin
      issue(int'($urandom_range(63)) - 32, int'($urandom_range(7)) - 4, 1);
      n = 6'($urandom); d = 3'($urandom);
      wait_rdy("rdy_rand");
      @(posedge clk); #1;
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
